// File: rtl/ioctl_stream_tx.sv
// ioctl_stream_tx: replays a byte stream onto the HPS ioctl download bus.
// Define IOCTL_TX_CHECKSUM_EN to add a running mod-256 sum of strobed bytes.
module ioctl_stream_tx #(
    parameter int ADDR_W      = 25,
    parameter int WR_GAP      = 4,
    parameter int POST_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        start_index,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              ioctl_wait,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    output logic              busy,
    output logic              done
`ifdef IOCTL_TX_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, WRITE, GAP, TAIL} state_t;

    localparam logic [7:0] GAP_LAST  = 8'(WR_GAP > 0 ? WR_GAP - 1 : 0);
    localparam logic [7:0] TAIL_LAST = 8'(POST_CYCLES - 1);

    state_t            state;
    logic [ADDR_W-1:0] remaining;
    logic [7:0]        cnt;

    assign s_ready = (state == FETCH);

    // In WRITE, ioctl_wr low means the strobe is still held off by ioctl_wait
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            remaining      <= '0;
            cnt            <= '0;
            ioctl_download <= 1'b0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            ioctl_index    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef IOCTL_TX_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
`ifdef IOCTL_TX_CHECKSUM_EN
                    checksum <= '0;
`endif
                    if (length != '0) begin
                        ioctl_index    <= start_index;
                        remaining      <= length;
                        ioctl_addr     <= '0;
                        ioctl_download <= 1'b1;
                        busy           <= 1'b1;
                        state          <= FETCH;
                    end else begin
                        done <= 1'b1;
                    end
                end
                FETCH: if (abort) begin
                    state <= TAIL;
                    cnt   <= TAIL_LAST;
                end else if (s_valid) begin
                    ioctl_dout <= s_data;
                    remaining  <= remaining - 1'b1;
                    ioctl_wr   <= !ioctl_wait;
                    state      <= WRITE;
                end
                WRITE: if (ioctl_wr) begin
                    ioctl_wr   <= 1'b0;
                    ioctl_addr <= ioctl_addr + 1'b1;
`ifdef IOCTL_TX_CHECKSUM_EN
                    checksum   <= checksum + ioctl_dout;
`endif
                    if (abort || remaining == '0) begin
                        state <= TAIL;
                        cnt   <= TAIL_LAST;
                    end else if (WR_GAP == 0) begin
                        state <= FETCH;
                    end else begin
                        state <= GAP;
                        cnt   <= GAP_LAST;
                    end
                end else if (abort) begin
                    state <= TAIL;
                    cnt   <= TAIL_LAST;
                end else begin
                    ioctl_wr <= !ioctl_wait;
                end
                GAP: if (abort) begin
                    state <= TAIL;
                    cnt   <= TAIL_LAST;
                end else if (cnt == '0) begin
                    state <= FETCH;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                TAIL: if (cnt == '0) begin
                    ioctl_download <= 1'b0;
                    busy           <= 1'b0;
                    done           <= 1'b1;
                    state          <= IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ioctl_stream_tx.sv
// tb_ioctl_stream_tx: directed checks of ioctl_stream_tx with default parameters.
module tb_ioctl_stream_tx;
    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    start_index = '0;
    logic [AW-1:0] length = '0;
    logic          abort = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          ioctl_wait = 1'b0;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          busy;
    logic          done;
`ifdef IOCTL_TX_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    ioctl_stream_tx #(.ADDR_W(AW), .WR_GAP(4), .POST_CYCLES(16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .start_index(start_index),
        .length(length), .abort(abort), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .ioctl_wait(ioctl_wait), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .busy(busy), .done(done)
`ifdef IOCTL_TX_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_fail = 0;

    // Passive monitor: cycle index, handshakes and strobes
    int cyc = 0;
    int hs_cnt = 0;
    int n_wr = 0;
    int hs_cyc [0:255];
    int wr_cyc [0:255];
    logic [AW-1:0] wr_addr [0:255];
    logic [7:0]    wr_dout [0:255];

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (s_ready && s_valid) begin
            hs_cyc[hs_cnt] <= cyc;
            hs_cnt <= hs_cnt + 1;
        end
        if (ioctl_wr) begin
            wr_cyc[n_wr]  <= cyc;
            wr_addr[n_wr] <= ioctl_addr;
            wr_dout[n_wr] <= ioctl_dout;
            n_wr <= n_wr + 1;
        end
    end

    logic [7:0] src [0:15];
    int base_wr, base_hs, end_cyc, abort_cyc;
    bit timed_out, hold_bad;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mark();
        base_wr = n_wr;
        base_hs = hs_cnt;
    endtask

    task automatic do_start(input logic [7:0] idx, input int len);
        s_valid = 1'b0;
        start_index = idx;
        length = AW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds src[] until done (or until stop_wr strobes); optional stall/abort injection
    task automatic run_xfer(input int vmode, input int wait_byte, input int abort_wr, input int stop_wr);
        int wcnt;
        bit waited, aborted;
        wcnt = 0;
        waited = 0;
        aborted = 0;
        timed_out = 0;
        hold_bad = 0;
        for (int i = 0; i < 400; i++) begin
            abort = 1'b0;
            if (done) begin
                end_cyc = cyc;
                return;
            end
            if (stop_wr > 0 && n_wr - base_wr >= stop_wr) return;
            s_valid = (vmode != 0) ? cyc[0] : 1'b1;
            s_data = src[(hs_cnt - base_hs) & 15];
            if (abort_wr > 0 && !aborted && n_wr - base_wr == abort_wr) begin
                abort = 1'b1;
                aborted = 1;
                abort_cyc = cyc;
            end
            if (wait_byte >= 0 && !waited && s_ready && s_valid && hs_cnt - base_hs == wait_byte) begin
                ioctl_wait = 1'b1;
                wcnt = 10;
                waited = 1;
            end
            tick();
            if (wcnt > 0) begin
                if (ioctl_wr || ioctl_addr != AW'(wait_byte) || ioctl_dout != src[wait_byte]) hold_bad = 1;
                wcnt--;
                if (wcnt == 0) ioctl_wait = 1'b0;
            end
        end
        abort = 1'b0;
        timed_out = 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_chk++;
        if ({ioctl_download, ioctl_wr, s_ready, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 00000", {ioctl_download, ioctl_wr, s_ready, busy, done});
        end
        n_chk++;
        if (ioctl_addr !== '0 || ioctl_dout !== 8'h00 || ioctl_index !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data got addr=%0h dout=%0h idx=%0h exp 0", ioctl_addr, ioctl_dout, ioctl_index);
        end
`ifdef IOCTL_TX_CHECKSUM_EN
        n_chk++;
        if (checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_checksum got %0h exp 0", checksum);
        end
`endif
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        mark();
        do_start(8'd0, 4);
        n_chk++;
        if ({busy, ioctl_download, s_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL basic_start got %b exp 111", {busy, ioctl_download, s_ready});
        end
        run_xfer(0, -1, 0, 0);
        n_chk++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL basic_timeout got timeout exp done");
        end
        n_chk++;
        if (n_wr - base_wr != 4) begin
            n_fail++;
            $display("FAIL basic_count got %0d exp 4", n_wr - base_wr);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (wr_addr[base_wr+i] !== AW'(i) || wr_dout[base_wr+i] !== src[i]) begin
                n_fail++;
                $display("FAIL basic_strobe%0d got addr=%0h dout=%0h exp addr=%0h dout=%0h",
                         i, wr_addr[base_wr+i], wr_dout[base_wr+i], i, src[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            n_chk++;
            if (wr_cyc[base_wr+i] - wr_cyc[base_wr+i-1] != 6) begin
                n_fail++;
                $display("FAIL basic_spacing%0d got %0d exp 6", i, wr_cyc[base_wr+i] - wr_cyc[base_wr+i-1]);
            end
        end
        n_chk++;
        if (end_cyc - wr_cyc[base_wr+3] != 17) begin
            n_fail++;
            $display("FAIL basic_done_delay got %0d exp 17", end_cyc - wr_cyc[base_wr+3]);
        end
        n_chk++;
        if ({ioctl_download, busy} !== 2'b00 || ioctl_addr !== AW'(4)) begin
            n_fail++;
            $display("FAIL basic_end got dl=%b busy=%b addr=%0h exp 0 0 4", ioctl_download, busy, ioctl_addr);
        end
`ifdef IOCTL_TX_CHECKSUM_EN
        n_chk++;
        if (checksum !== 8'hAA) begin
            n_fail++;
            $display("FAIL basic_checksum got %0h exp aa", checksum);
        end
`endif
        tick();
        n_chk++;
        if (done !== 1'b0 || ioctl_addr !== AW'(4) || ioctl_dout !== 8'h44) begin
            n_fail++;
            $display("FAIL basic_hold got done=%b addr=%0h dout=%0h exp 0 4 44", done, ioctl_addr, ioctl_dout);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 8; i++) src[i] = 8'(8'hA0 + i * 3);
        mark();
        do_start(8'd254, 8);
        n_chk++;
        if (ioctl_index !== 8'd254) begin
            n_fail++;
            $display("FAIL toggle_index got %0d exp 254", ioctl_index);
        end
        run_xfer(1, -1, 0, 0);
        n_chk++;
        if (timed_out || n_wr - base_wr != 8) begin
            n_fail++;
            $display("FAIL toggle_count got %0d timeout=%b exp 8", n_wr - base_wr, timed_out);
        end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (wr_addr[base_wr+i] !== AW'(i) || wr_dout[base_wr+i] !== src[i]
                || wr_cyc[base_wr+i] - hs_cyc[base_hs+i] != 1) begin
                n_fail++;
                $display("FAIL toggle_strobe%0d got addr=%0h dout=%0h lag=%0d exp addr=%0h dout=%0h lag=1",
                         i, wr_addr[base_wr+i], wr_dout[base_wr+i], wr_cyc[base_wr+i] - hs_cyc[base_hs+i], i, src[i]);
            end
        end
    endtask

    task automatic test_wait();
        src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h5A; src[3] = 8'h04;
        mark();
        do_start(8'd3, 4);
        run_xfer(0, 2, 0, 0);
        n_chk++;
        if (timed_out || n_wr - base_wr != 4) begin
            n_fail++;
            $display("FAIL wait_count got %0d timeout=%b exp 4", n_wr - base_wr, timed_out);
        end
        n_chk++;
        if (hold_bad) begin
            n_fail++;
            $display("FAIL wait_hold got unstable addr/dout or early strobe exp stable");
        end
        n_chk++;
        if (wr_cyc[base_wr+2] - hs_cyc[base_hs+2] != 11) begin
            n_fail++;
            $display("FAIL wait_delay got %0d exp 11", wr_cyc[base_wr+2] - hs_cyc[base_hs+2]);
        end
        n_chk++;
        if (wr_addr[base_wr+2] !== AW'(2) || wr_dout[base_wr+2] !== 8'h5A) begin
            n_fail++;
            $display("FAIL wait_strobe got addr=%0h dout=%0h exp 2 5a", wr_addr[base_wr+2], wr_dout[base_wr+2]);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 5; i++) src[i] = 8'(8'h30 + i);
        mark();
        do_start(8'd1, 5);
        run_xfer(0, -1, 2, 0);
        n_chk++;
        if (timed_out || n_wr - base_wr != 2) begin
            n_fail++;
            $display("FAIL abort_count got %0d timeout=%b exp 2", n_wr - base_wr, timed_out);
        end
        n_chk++;
        if (end_cyc - abort_cyc != 17) begin
            n_fail++;
            $display("FAIL abort_tail got %0d exp 17", end_cyc - abort_cyc);
        end
        n_chk++;
        if (ioctl_addr !== AW'(2) || ioctl_download !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_end got addr=%0h dl=%b exp 2 0", ioctl_addr, ioctl_download);
        end
    endtask

    task automatic test_zero_and_busy();
        do_start(8'd9, 0);
        n_chk++;
        if ({done, ioctl_download, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_done got %b exp 100", {done, ioctl_download, busy});
        end
        tick();
        n_chk++;
        if ({done, ioctl_download, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_after got %b exp 000", {done, ioctl_download, busy});
        end
        src[0] = 8'h77; src[1] = 8'h88;
        mark();
        do_start(8'd5, 2);
        start_index = 8'd7;
        length = AW'(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_xfer(0, -1, 0, 0);
        n_chk++;
        if (timed_out || n_wr - base_wr != 2 || ioctl_addr !== AW'(2) || ioctl_index !== 8'd5) begin
            n_fail++;
            $display("FAIL busy_start got n=%0d addr=%0h idx=%0d exp 2 2 5", n_wr - base_wr, ioctl_addr, ioctl_index);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) src[i] = 8'(8'hC0 + i);
        mark();
        do_start(8'd6, 5);
        run_xfer(0, -1, 0, 3);
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({ioctl_download, ioctl_wr, s_ready, busy, done} !== 5'b0 || ioctl_addr !== '0
            || ioctl_dout !== 8'h00 || ioctl_index !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset got ctl=%b addr=%0h dout=%0h idx=%0h exp 0",
                     {ioctl_download, ioctl_wr, s_ready, busy, done}, ioctl_addr, ioctl_dout, ioctl_index);
        end
        tick();
        #2 reset_n = 1'b1;
        tick();
        src[0] = 8'hE1; src[1] = 8'hE2;
        mark();
        do_start(8'd2, 2);
        run_xfer(0, -1, 0, 0);
        n_chk++;
        if (timed_out || n_wr - base_wr != 2 || wr_addr[base_wr] !== '0 || wr_dout[base_wr] !== 8'hE1
            || ioctl_addr !== AW'(2)) begin
            n_fail++;
            $display("FAIL midreset_restart got n=%0d addr0=%0h dout0=%0h end=%0h exp 2 0 e1 2",
                     n_wr - base_wr, wr_addr[base_wr], wr_dout[base_wr], ioctl_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_wait();
        test_abort();
        test_zero_and_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
